// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: one-cycle logic/arith/shift ops plus an iterative
// shift-add unsigned multiply, with a Start/Busy/Done handshake.
module alu_exec_unit #(
  parameter int N = 16
) (
  input  logic         Clock_i,
  input  logic         Reset_i,
  input  logic         Start_i,
  input  logic [3:0]   AluControl_i,
  input  logic [N-1:0] A_i,
  input  logic [N-1:0] B_i,
  output logic [N-1:0] Rezultati_o,
  output logic         Zero_o,
  output logic         Overflow_o,
  output logic         Gabim_o,
  output logic         Busy_o,
  output logic         Done_o
);

  localparam int SW = $clog2(N);
  localparam int CW = $clog2(N + 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] OP_ADDI = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_MUL  = 4'b0111;
  localparam logic [3:0] OP_SUB  = 4'b1100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  typedef struct packed {
    logic [N-1:0] res;
    logic         ov;
    logic         gab;
  } alu_rsp_t;

  state_e         state_q, state_d;
  logic [N-1:0]   res_q, res_d;
  logic           zero_q, zero_d;
  logic           ov_q, ov_d;
  logic           gab_q, gab_d;
  logic [2*N-1:0] mcand_q, mcand_d;
  logic [N-1:0]   mplier_q, mplier_d;
  logic [2*N-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  // Log-depth barrel shifters; only B[SW-1:0] steers the stages.
  logic [SW:0][N-1:0] sll_stg, srl_stg;
  assign sll_stg[0] = A_i;
  assign srl_stg[0] = A_i;
  for (genvar i = 0; i < SW; i++) begin : g_shift
    assign sll_stg[i+1] = B_i[i] ? (sll_stg[i] << (1 << i)) : sll_stg[i];
    assign srl_stg[i+1] = B_i[i] ? (srl_stg[i] >> (1 << i)) : srl_stg[i];
  end

  logic [N-1:0] bneg, sum, diff;
  assign bneg = ~B_i + {{(N-1){1'b0}}, 1'b1};
  assign sum  = A_i + B_i;
  assign diff = A_i + bneg;

  alu_rsp_t rsp;
  always_comb begin
    rsp = '0;
    unique case (AluControl_i)
      OP_AND:  rsp.res = A_i & B_i;
      OP_OR:   rsp.res = A_i | B_i;
      OP_XOR:  rsp.res = A_i ^ B_i;
      OP_ADD, OP_ADDI: begin
        rsp.res = sum;
        rsp.ov  = (A_i[N-1] == B_i[N-1]) && (sum[N-1] != A_i[N-1]);
      end
      OP_SUB: begin
        rsp.res = diff;
        rsp.ov  = (A_i[N-1] == bneg[N-1]) && (diff[N-1] != A_i[N-1]);
      end
      OP_SLL:  rsp.res = sll_stg[SW];
      OP_SRL:  rsp.res = srl_stg[SW];
      OP_MUL:  rsp.res = '0;
      default: rsp.gab = 1'b1;
    endcase
  end

  logic [2*N-1:0] acc_step;
  assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  always_comb begin
    state_d  = state_q;
    res_d    = res_q;
    zero_d   = zero_q;
    ov_d     = ov_q;
    gab_d    = gab_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (Start_i) begin
          if (AluControl_i == OP_MUL) begin
            state_d  = S_MUL;
            mcand_d  = {{N{1'b0}}, A_i};
            mplier_d = B_i;
            acc_d    = '0;
            cnt_d    = CW'(N);
          end else begin
            state_d = S_DONE;
            res_d   = rsp.res;
            zero_d  = (rsp.res == '0);
            ov_d    = rsp.ov;
            gab_d   = rsp.gab;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - 1'b1;
        // Last iteration: commit from the step value, not the stale accumulator.
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
          res_d   = acc_step[N-1:0];
          zero_d  = (acc_step[N-1:0] == '0);
          ov_d    = |acc_step[2*N-1:N];
          gab_d   = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock_i) begin
    if (Reset_i) begin
      state_q  <= S_IDLE;
      res_q    <= '0;
      zero_q   <= 1'b1;
      ov_q     <= 1'b0;
      gab_q    <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      ov_q     <= ov_d;
      gab_q    <= gab_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign Rezultati_o = res_q;
  assign Zero_o      = zero_q;
  assign Overflow_o  = ov_q;
  assign Gabim_o     = gab_q;
  assign Busy_o      = (state_q == S_MUL);
  assign Done_o      = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed vector bench for alu_exec_unit (N=16) plus multi-cycle corner sequences.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [3:0]  ctrl;
  logic [15:0] a, b;
  logic [15:0] res;
  logic        zero, ovf, gab, busy, done;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.N(16)) dut (
    .Clock_i(clk), .Reset_i(rst), .Start_i(start), .AluControl_i(ctrl),
    .A_i(a), .B_i(b), .Rezultati_o(res), .Zero_o(zero), .Overflow_o(ovf),
    .Gabim_o(gab), .Busy_o(busy), .Done_o(done)
  );

  typedef struct {
    logic [3:0]  c;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic        z;
    logic        ov;
    logic        g;
    int          lat;
    int          bsy;
  } vec_t;

  vec_t v[15];

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s[%0d] got %h want %h", nm, idx, act, exp);
    else passed++;
  endtask

  // Pulses Start for one edge, scrambles inputs, then waits (bounded) for Done.
  task automatic issue(input logic [3:0] c, input logic [15:0] av, input logic [15:0] bv,
                       output int lat, output int bsy);
    @(negedge clk);
    ctrl = c; a = av; b = bv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF; ctrl = 4'b0100;
    lat = 1; bsy = 0;
    while (!done && lat < 40) begin
      if (busy) bsy++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  int lat, bsy, dcnt, dcyc;
  logic [15:0] dres;

  initial begin
    rst = 1'b1; start = 1'b0; ctrl = '0; a = '0; b = '0;
    //            code     A         B         R         Z  OV G  lat bsy
    v[0]  = '{4'b0100, 16'h7FFF, 16'h0001, 16'h8000, 0, 1, 0, 1,  0};
    v[1]  = '{4'b1100, 16'h0005, 16'h0005, 16'h0000, 1, 0, 0, 1,  0};
    v[2]  = '{4'b0001, 16'h0001, 16'h0013, 16'h0008, 0, 0, 0, 1,  0};
    v[3]  = '{4'b0110, 16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 1,  0};
    v[4]  = '{4'b0111, 16'h0012, 16'h0034, 16'h03A8, 0, 0, 0, 17, 16};
    v[5]  = '{4'b0111, 16'h0100, 16'h0100, 16'h0000, 1, 1, 0, 17, 16};
    v[6]  = '{4'b1111, 16'h1234, 16'h5678, 16'h0000, 1, 0, 1, 1,  0};
    v[7]  = '{4'b0011, 16'h00FF, 16'h0F0F, 16'h0FF0, 0, 0, 0, 1,  0};
    v[8]  = '{4'b0000, 16'hF0F0, 16'hFF00, 16'hF000, 0, 0, 0, 1,  0};
    v[9]  = '{4'b0010, 16'h00F0, 16'h0F00, 16'h0FF0, 0, 0, 0, 1,  0};
    v[10] = '{4'b0101, 16'h8000, 16'h8000, 16'h0000, 1, 1, 0, 1,  0};
    v[11] = '{4'b1100, 16'h8000, 16'h0001, 16'h7FFF, 0, 1, 0, 1,  0};
    v[12] = '{4'b0111, 16'hFFFF, 16'hFFFF, 16'h0001, 0, 1, 0, 17, 16};
    v[13] = '{4'b1000, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 1, 1,  0};
    v[14] = '{4'b0100, 16'h0003, 16'h0004, 16'h0007, 0, 0, 0, 1,  0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_res", 0, 32'(res), 32'h0);
    chk("rst_zero", 0, 32'(zero), 32'h1);
    chk("rst_flags", 0, {29'h0, ovf, gab, busy}, 32'h0);
    chk("rst_done", 0, 32'(done), 32'h0);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      issue(v[i].c, v[i].a, v[i].b, lat, bsy);
      chk("res", i, 32'(res), 32'(v[i].r));
      chk("zero", i, 32'(zero), 32'(v[i].z));
      chk("ovf", i, 32'(ovf), 32'(v[i].ov));
      chk("gab", i, 32'(gab), 32'(v[i].g));
      chk("lat", i, lat, v[i].lat);
      chk("busy", i, bsy, v[i].bsy);
      @(posedge clk); #1;
      chk("done_pulse", i, 32'(done), 32'h0);
    end

    // Start in the Done cycle must be dropped.
    issue(4'b0100, 16'h0001, 16'h0001, lat, bsy);
    chk("b2b_lat", 0, lat, 1);
    start = 1'b1; ctrl = 4'b0111; a = 16'h0002; b = 16'h0003;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("b2b_ignored", 0, {30'h0, busy, done}, 32'h0);
    chk("b2b_res", 0, 32'(res), 32'h2);

    // Start with new operands mid-multiply must not disturb the product.
    @(negedge clk);
    ctrl = 4'b0111; a = 16'h0012; b = 16'h0034; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dcnt = 0; dcyc = 0; dres = '0;
    for (int cyc = 1; cyc <= 25; cyc++) begin
      if (cyc == 5) begin start = 1'b1; ctrl = 4'b0100; a = 16'h1111; b = 16'h2222; end
      @(posedge clk); #1;
      if (cyc == 5) start = 1'b0;
      if (done) begin dcnt++; dcyc = cyc + 1; dres = res; end
    end
    chk("midmul_dcnt", 0, dcnt, 1);
    chk("midmul_dcyc", 0, dcyc, 17);
    chk("midmul_res", 0, 32'(dres), 32'h03A8);

    // Reset mid-multiply aborts with no Done.
    @(negedge clk);
    ctrl = 4'b0111; a = 16'h0012; b = 16'h0034; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (7) begin @(posedge clk); #1; end
    chk("pre_rst_busy", 0, 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mrst_res", 0, 32'(res), 32'h0);
    chk("mrst_zero", 0, 32'(zero), 32'h1);
    chk("mrst_flags", 0, {28'h0, ovf, gab, busy, done}, 32'h0);
    dcnt = 0;
    repeat (20) begin @(posedge clk); #1; if (done || busy) dcnt++; end
    chk("mrst_quiet", 0, dcnt, 0);

    // Reset and Start together: Start is dropped.
    @(negedge clk);
    rst = 1'b1; start = 1'b1; ctrl = 4'b0100; a = 16'h0001; b = 16'h0001;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    dcnt = 0;
    repeat (3) begin @(posedge clk); #1; if (done || busy) dcnt++; end
    chk("rst_start_drop", 0, dcnt, 0);
    chk("rst_start_res", 0, 32'(res), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Multi-cycle ALU execution unit that consumes the 4-bit ALU control code produced by the ALU control decoder and executes the selected operation on two N-bit operands. Single-cycle logical, arithmetic and shift operations complete in one cycle. Multiplication is an iterative shift-add sequence. It sits in the execute stage between the register-file read and the write-back mux, and uses a Start/Busy/Done handshake so the control FSM can stall while a multiply is in progress.

## Interface
- N, 16, operand/result width (power of two, >= 8)
- Clock  in  1  rising-edge clock; single clock domain
- Reset  in  1  synchronous, active-high; clears all state on the sampling edge
- Start  in  1  request; sampled only in IDLE
- AluControl  in  4  operation code, captured with Start
- A  in  N  operand A, captured with Start
- B  in  N  operand B, captured with Start
- Rezultati  out  N  registered result; holds until next completion
- Zero  out  1  Rezultati == 0; updated with Rezultati
- Overflow  out  1  signed overflow (add/sub) or product overflow (mul); 0 for other ops
- Gabim  out  1  undefined AluControl code on last completed op
- Busy  out  1  high while a multiply iterates
- Done  out  1  one-cycle completion pulse

## Operation
- Codes:
  - 0000 AND
  - 0010 OR
  - 0011 XOR
  - 0100 ADD
  - 0101 ADD (immediate path; identical arithmetic)
  - 1100 SUB (A-B)
  - 0001 SLL A by B[log2N-1:0]
  - 0110 SRL A by B[log2N-1:0], logical
  - 0111 MUL, unsigned
  - any other code: Rezultati=0, Gabim=1, single-cycle
- FSM states: IDLE, MUL, DONE.
  - IDLE + Start + code!=0111 -> DONE. Result and flags are registered on that edge.
  - IDLE + Start + code==0111 -> MUL. Load multiplicand and multiplier, clear the 2N-bit accumulator, set counter=N.
  - MUL: each edge adds the multiplicand (shifted) when the current multiplier bit is 1, shifts, and decrements the counter. When the counter reaches 0 -> DONE and Rezultati is registered.
  - DONE -> IDLE unconditionally. Done=1 only in DONE.
- Arithmetic and width rules:
  - ADD/SUB results are modulo 2^N.
  - Overflow = (sign A == sign B') && (sign result != sign A), where B' = B for ADD and ~B+1 for SUB.
  - MUL: Rezultati = product[N-1:0]; Overflow = |product[2N-1:N].
  - Shift amount uses only the low log2N bits of B; upper bits are ignored.
- Gabim is cleared on every completion of a defined code.
- Start while in MUL or DONE is ignored: no queueing, no effect on the operation in flight.
- A, B and AluControl may change freely after the Start edge; the operands are captured.

## Timing
- Reset values: Rezultati=0, Zero=1, Overflow=0, Gabim=0, Busy=0, Done=0, state=IDLE, counter=0.
- Start sampled at edge k (IDLE):
  - Non-MUL: Done=1 and Rezultati/flags valid in cycle k+1. Latency is 1.
  - MUL: Busy=1 in cycles k+1..k+N. Done=1, Busy=0 and Rezultati valid in cycle k+N+1. Latency is N+1.
- Back-to-back: Start asserted in the Done cycle is ignored (state is DONE). The next accepted Start is in cycle k+2 for a single-cycle op.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset asserted in any cycle, including mid-MUL or the Done cycle: the next edge returns all outputs to their reset values. The aborted operation never produces Done.
- Reset and Start in the same cycle: Reset wins and Start is dropped.

## Test plan
- ADD 0x7FFF + 0x0001 (code 0100), Start at edge k -> cycle k+1: Rezultati=0x8000, Overflow=1, Zero=0, Done=1 for exactly one cycle.
- SUB 0x0005 - 0x0005 (code 1100) -> Rezultati=0x0000, Zero=1, Overflow=0. Then SLL 0x0001 by B=0x0013 -> Rezultati=0x0008. Then SRL 0x8000 by 0x000F -> 0x0001.
- MUL 0x0012 * 0x0034 (code 0111) -> Busy high for 16 cycles; Done in cycle k+17 with Rezultati=0x03A8, Overflow=0. MUL 0x0100 * 0x0100 -> Rezultati=0x0000, Zero=1, Overflow=1.
- During a MUL, pulse Start with code 0100 and change A/B at cycle k+5 -> ignored; final result still 0x03A8; exactly one Done.
- Reset asserted at cycle k+8 of a MUL -> next cycle all outputs at reset values, Busy=0; no Done for 20 following cycles without Start.
- Code 1111 -> Done at k+1, Rezultati=0, Gabim=1. A subsequent XOR 0x00FF ^ 0x0F0F -> Rezultati=0x0FF0, Gabim=0.
